reg_dump_reader: RTL and testbench
==================================

REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameter NUM_REGS, default 9, number of register-file entries dumped ($0-$7 plus ra at address 8).
REQ-002 Parameter LAST_SEP, default 8'h0A, separator byte sent after the final register.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a full dump; sampled only in IDLE.
REQ-006 ra  output  4  register-file read address, driven from the internal index register.
REQ-007 rd  input  8  register-file read data, combinational from ra.
REQ-008 out_data  output  8  ASCII byte to the consumer (LCD/UART writer).
REQ-009 out_valid  output  1  out_data holds a valid byte.
REQ-010 out_ready  input  1  consumer accepts the byte; transfer occurs on out_valid & out_ready at a rising edge.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  single-cycle pulse after the last byte transfers.

Function
REQ-013 States SHALL be IDLE, CAPTURE, SEND_HI, SEND_LO, SEND_SEP, DONE.
REQ-014 IDLE with start=1 at edge k: idx<=0, state<=CAPTURE; ra=0 from after edge k.
REQ-015 CAPTURE: at next edge, data_q<=rd (ra stable for one full cycle), state<=SEND_HI.
REQ-016 SEND_HI: out_valid=1, out_data=ASCII of data_q[7:4]; on transfer, state<=SEND_LO.
REQ-017 SEND_LO: out_valid=1, out_data=ASCII of data_q[3:0]; on transfer, state<=SEND_SEP.
REQ-018 SEND_SEP: out_valid=1, out_data=8'h20 when idx<NUM_REGS-1, else LAST_SEP.
REQ-019 SEND_SEP transfer with idx<NUM_REGS-1: idx<=idx+1, state<=CAPTURE; otherwise state<=DONE.
REQ-020 DONE: done=1 for exactly one cycle, then state<=IDLE; idx<=0.
REQ-021 Hex-to-ASCII: nibble 0-9 -> 8'h30-8'h39; A-F -> 8'h41-8'h46 (uppercase).
REQ-022 While out_valid=1 and out_ready=0, out_data and state SHALL hold unchanged (no byte dropped or repeated).
REQ-023 out_valid SHALL be 0 in IDLE, CAPTURE and DONE.
REQ-024 start asserted while busy=1 SHALL be ignored; no queued restart.
REQ-025 start held high continuously SHALL begin a new dump on the first IDLE cycle after DONE.
REQ-026 Each register SHALL be sampled at its own CAPTURE cycle; writes to the register file during a dump are visible for registers not yet captured.
REQ-027 With out_ready tied high, a full dump SHALL take 4*NUM_REGS cycles from the start edge to entering DONE (36 for default).
REQ-028 idx SHALL never exceed NUM_REGS-1; ra never addresses beyond 8 at default.

Reset
REQ-029 RST_n low SHALL immediately force state=IDLE, idx=0, ra=0, data_q=0, out_valid=0, out_data=0, busy=0, done=0, including mid-dump; no partial byte stream resumes after release.
REQ-030 The first rising edge with RST_n high SHALL be treated as IDLE with normal start sampling.

Structure
REQ-031 State encoding, ASCII constants (8'h20, 8'h0A, 8'h30, 8'h41) and NUM_REGS default SHALL live in a shared package/header regdump_pkg.
REQ-032 A single combinational sub-module nibble_to_ascii (4-bit in, 8-bit out) SHALL implement REQ-021.

Verification
REQ-033 Regs $0..$8 = 00,3C,FF,A5,10,09,7E,B2,41, out_ready=1, start pulse -> bytes "00 3C FF A5 10 09 7E B2 41\n" (27 bytes), done pulse 37 cycles after the start edge.
REQ-034 Same data, out_ready toggling 1-0-1-0 -> identical 27-byte stream, each byte held stable while out_ready=0.
REQ-035 start re-pulsed during dump at byte 5 -> stream unaffected, exactly one done pulse.
REQ-036 RST_n low during SEND_LO of register $3 -> out_valid=0 same cycle, busy=0; new start after release yields full 27-byte stream from $0.
REQ-037 Write $5<=C3 during capture of $2, then $1<=99 -> dump shows C3 for $5 and the old value for $1.
REQ-038 All 16 nibble values in $1 (0x01..0xEF sweep) -> ASCII 0-9/A-F exact per REQ-021.

Source files
------------

// File: rtl/regdump_pkg.sv
// rtl/regdump_pkg.sv - shared state encoding and ASCII constants for the register dump reader
// Ports: none (package only).
package regdump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_SEND_HI  = 3'd2,
    ST_SEND_LO  = 3'd3,
    ST_SEND_SEP = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  localparam int NUM_REGS_DEFAULT = 9;

endpackage

// File: rtl/reg_dump_reader_nibble_to_ascii.sv
// rtl/reg_dump_reader_nibble_to_ascii.sv - combinational hex nibble to uppercase ASCII
// Ports:
//   nibble : 4-bit value 0..F
//   ascii  : '0'..'9' or 'A'..'F'
module nibble_to_ascii
  import regdump_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_ZERO;
    if (nibble < 4'd10) begin
      ascii = ASCII_ZERO + {4'h0, nibble};
    end else begin
      ascii = ASCII_A + {4'h0, nibble - 4'd10};
    end
  end

endmodule

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - walks the register file and streams each entry as two hex chars plus a separator
// Ports:
//   CLK, RST_n      : clock, asynchronous active-low reset
//   start           : begin a full dump (only honoured while idle)
//   ra / rd         : register-file read address / combinational read data
//   out_data/valid  : ASCII byte stream to the consumer, out_ready is its accept
//   busy            : high whenever not idle
//   done            : one-cycle pulse after the final separator is accepted
module reg_dump_reader
  import regdump_pkg::*;
#(
  parameter int         NUM_REGS = NUM_REGS_DEFAULT,
  parameter logic [7:0] LAST_SEP = ASCII_LF
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       start,
  output logic [3:0] ra,
  input  logic [7:0] rd,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       xfer;
  logic [7:0] hi_ascii;
  logic [7:0] lo_ascii;

  // Characters are derived from the next-cycle data so the outputs can be
  // registered alongside the state they belong to.
  nibble_to_ascii u_hi (
    .nibble (data_d[7:4]),
    .ascii  (hi_ascii)
  );

  nibble_to_ascii u_lo (
    .nibble (data_d[3:0]),
    .ascii  (lo_ascii)
  );

  assign xfer = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    data_d      = data_q;
    out_data_d  = 8'h00;
    out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = 4'd0;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        data_d  = rd;
        state_d = ST_SEND_HI;
      end
      ST_SEND_HI: begin
        if (xfer) state_d = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        if (xfer) state_d = ST_SEND_SEP;
      end
      ST_SEND_SEP: begin
        if (xfer) begin
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        idx_d   = 4'd0;
        state_d = ST_IDLE;
      end
      default: begin
        idx_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase

    // A stalled byte keeps state and data, so the recomputed outputs match
    // the current ones and nothing is dropped or repeated.
    case (state_d)
      ST_SEND_HI: begin
        out_valid_d = 1'b1;
        out_data_d  = hi_ascii;
      end
      ST_SEND_LO: begin
        out_valid_d = 1'b1;
        out_data_d  = lo_ascii;
      end
      ST_SEND_SEP: begin
        out_valid_d = 1'b1;
        out_data_d  = (idx_d < LAST_IDX) ? ASCII_SPACE : LAST_SEP;
      end
      default: begin
        out_valid_d = 1'b0;
        out_data_d  = 8'h00;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 4'd0;
      data_q      <= 8'h00;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ra        = idx_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - scoreboard bench for reg_dump_reader
module tb_reg_dump_reader;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] ra;
  logic [7:0] rd;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       busy;
  logic       done;

  logic [7:0] regs [16];
  logic [7:0] exp_regs [9];

  assign rd = regs[ra];

  reg_dump_reader dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .start     (start),
    .ra        (ra),
    .rd        (rd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] sb [$];
  int   rx_count = 0;
  int   done_count = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  bit   toggle_mode = 1'b0;
  bit   prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  string hexchars = "0123456789ABCDEF";

  always @(posedge CLK) cyc <= cyc + 1;

  // Consumer: decides out_ready for the coming edge, then scores the byte
  // that edge will transfer.
  always @(negedge CLK) begin
    if (toggle_mode) out_ready = ~out_ready;
    else             out_ready = 1'b1;
    if (prev_stall && RST_n) begin
      check_val("hold_data", out_data, prev_data);
      check_val("hold_valid", out_valid, 1);
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) check_val("sb_empty", sb.size(), 1);
      else check_val($sformatf("byte%0d", rx_count), out_data, sb.pop_front());
      rx_count++;
    end
    if (done) done_count++;
  end

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return hexchars[n];
  endfunction

  task automatic push_dump();
    for (int i = 0; i < 9; i++) begin
      sb.push_back(hex_char(exp_regs[i][7:4]));
      sb.push_back(hex_char(exp_regs[i][3:0]));
      sb.push_back((i < 8) ? 8'h20 : 8'h0A);
    end
  endtask

  task automatic load_default();
    logic [7:0] d [9];
    d = '{8'h00, 8'h3C, 8'hFF, 8'hA5, 8'h10, 8'h09, 8'h7E, 8'hB2, 8'h41};
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    for (int i = 0; i < 9; i++) begin
      regs[i]     = d[i];
      exp_regs[i] = d[i];
    end
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(output int lat);
    int n = 0;
    while (!done && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    check_val("done_seen", done, 1);
    // The done cycle is consumed at the edge that ends it.
    lat = cyc - start_cyc + 1;
  endtask

  task automatic finish_dump();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check_val("drain", sb.size(), 0);
    check_val("idle_after", busy, 0);
  endtask

  initial begin
    int lat;
    int base;
    int n;
    logic [7:0] sweep [8];

    load_default();
    #12;
    check_val("rst_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ra", ra, 0);
    check_val("rst_data", out_data, 0);

    // Start already high while in reset: first edge after release starts the dump.
    push_dump();
    start = 1'b1;
    @(negedge CLK); RST_n = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    start_cyc = cyc;
    check_val("busy_on_start", busy, 1);
    check_val("ra_first", ra, 0);
    wait_done(lat);
    check_val("done_latency", lat, 37);
    finish_dump();

    // Backpressure: out_ready alternates every cycle.
    toggle_mode = 1'b1;
    push_dump();
    pulse_start();
    wait_done(lat);
    finish_dump();
    toggle_mode = 1'b0;

    // Start re-pulsed mid-dump is ignored.
    base = rx_count;
    n = done_count;
    push_dump();
    fork
      begin
        pulse_start();
        wait_done(lat);
        finish_dump();
      end
      begin
        int k = 0;
        while (rx_count < base + 5 && k < 200) begin
          @(posedge CLK); #1;
          k++;
        end
        start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
      end
    join
    repeat (20) @(posedge CLK);
    #1;
    check_val("single_done", done_count - n, 1);
    check_val("no_restart", busy, 0);

    // Reset during SEND_LO of register 3.
    base = rx_count;
    push_dump();
    pulse_start();
    n = 0;
    while (rx_count < base + 10 && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    check_val("reached_lo3", rx_count - base, 10);
    RST_n = 1'b0;
    #1;
    check_val("midrst_valid", out_valid, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_ra", ra, 0);
    sb.delete();
    repeat (3) @(posedge CLK);
    #1 RST_n = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_val("no_resume", busy, 0);
    push_dump();
    pulse_start();
    wait_done(lat);
    check_val("post_rst_latency", lat, 37);
    finish_dump();

    // Register writes during the dump: $5 captured later sees new value, $1 does not.
    exp_regs[5] = 8'hC3;
    push_dump();
    fork
      begin
        pulse_start();
        wait_done(lat);
        finish_dump();
      end
      begin
        int k = 0;
        while (!(ra == 4'd2 && busy && !out_valid) && k < 200) begin
          @(posedge CLK); #1;
          k++;
        end
        check_val("cap2_found", ra, 2);
        regs[5] = 8'hC3;
        regs[1] = 8'h99;
      end
    join
    load_default();

    // Nibble sweep through $1.
    sweep = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    for (int s = 0; s < 8; s++) begin
      regs[1] = sweep[s];
      exp_regs[1] = sweep[s];
      push_dump();
      pulse_start();
      wait_done(lat);
      finish_dump();
    end
    load_default();

    // Start held high: a second dump begins on the first idle cycle after DONE.
    push_dump();
    push_dump();
    @(posedge CLK); #1 start = 1'b1;
    start_cyc = cyc;
    wait_done(lat);
    @(posedge CLK); #1;
    check_val("gap_idle", busy, 0);
    @(posedge CLK); #1;
    check_val("held_restart", busy, 1);
    start = 1'b0;
    wait_done(lat);
    finish_dump();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
